switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
Per-router switch allocator for the 5-port mesh router (port 0..4: local, N, E, S, W). It generates the one-hot crossbar selects sel0..sel4 (sel_o[i]=1 means output o is driven from input i). It holds each output for one input until that input's tail flit passes. Arbitration among inputs contending for the same idle output is round-robin, with an independent pointer per output.

Parameters:
NP, 5, number of router ports; fixed at 5 to match the crossbar port list
DW, 3, width of each destination-port index

Ports:
clk  input  1  router clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  5  req[i]=1: input buffer i has a valid flit at head
dst0..dst4  input  3 each  output port index (0..4) requested by input i; valid while req[i]=1
tail  input  5  tail[i]=1: head flit of input i is the packet's tail (single-flit packet: head=tail)
out_ready  input  5  out_ready[o]=1: downstream of output o can accept a flit this cycle (credit available)
sel0..sel4  output  5 each  registered one-hot crossbar select per output; 5'b00000 = output unused
gnt  output  5  gnt[i]=1: input i's head flit traverses the crossbar this cycle and must be dequeued

Behaviour:
- Per output o state: IDLE / LOCKED(owner), plus round-robin pointer ptr_o (0..4).
- Reset (rst=0, async): all outputs IDLE, all ptr_o=0, sel0..sel4=5'b00000, gnt=0.
- Candidate set for IDLE output o:
  - inputs i with req[i]=1, dst_i==o, and i not currently owner of any output.
  - dst_i>4 is ignored: never a candidate, no other effect.
- Arbitration (IDLE output, candidates non-empty):
  - winner = first candidate scanning i = ptr_o, ptr_o+1, … mod 5.
  - At the next edge: state becomes LOCKED(winner), sel_o = one-hot(winner), ptr_o = (winner+1) mod 5.
  - No candidates: stays IDLE, sel_o = 0, ptr_o unchanged.
- An input can win only one output per cycle. Its single dst guarantees this; if two outputs would pick the same input, the lower-numbered output wins and the other re-arbitrates next cycle.
- gnt is combinational from registered state: gnt[i] = (i owns output o) & req[i] & out_ready[o]. gnt is 0 for non-owners.
- Latency: first gnt no earlier than 1 cycle after the request is first sampled, i.e. the lock cycle plus one.
- Release: if gnt[i]=1 and tail[i]=1 while LOCKED(i) on output o, then at the next edge output o becomes IDLE and sel_o=0.
- A released output does not re-arbitrate on the release edge. There is one bubble cycle; a new lock occurs on the edge after.
- Owner drops req mid-packet: lock held, gnt[i]=0, sel_o unchanged.
- out_ready[o]=0: lock held, gnt=0; resumes when out_ready returns.
- Owner's dst change while LOCKED is ignored; the lock follows the original output until tail.
- Simultaneous events:
  - Outputs arbitrate independently in the same cycle.
  - Release on one output and lock on another occur on the same edge.
- Reset asserted mid-packet: all locks dropped immediately. Upstream is responsible for flushing partial packets.
- sel one-hot invariant: each sel_o is 0 or exactly one bit set. No input index appears in two sel_o at once.

Test Plan:
1. Reset then req=5'b00010, dst1=2, tail=5'b00010, out_ready=5'b11111 → edge 1: sel2=5'b00010, gnt=0. Cycle 2: gnt=5'b00010. Edge 2: sel2=0. ptr_2=2.
2. Contention: inputs 0,1,3 all dst=4, multi-flit (tail=0 until the 3rd gnt) → sel4=00001 first. After input 0's tail plus a 1-cycle bubble, sel4=00010, then 01000. Order is round-robin 0→1→3.
3. Backpressure: input 2 locked on output 0 with out_ready[0]=0 for 4 cycles → gnt[2]=0 and sel0=00100 held. out_ready[0]=1 → gnt[2]=1.
4. Parallel: input0→3, input1→2, input4→0 requested in the same cycle → after one edge sel3=00001, sel2=00010, sel0=10000. gnt=5'b10011 with all ready.
5. Invalid dst: req[3]=1, dst3=7 for 10 cycles → all sel=0, gnt=0.
6. Async reset mid-packet: rst low between edges while sel1=00100 → sel1=0 and gnt=0 immediately. After release, a fresh request from input 4 to output 1 wins first only if no input 0..3 competes (ptr reset to 0).

Source files
------------

// File: rtl/switch_allocator.sv
// Switch allocator for the 5-port mesh router.
// Each output is either idle or locked to one input until that input's tail
// flit crosses. Idle outputs pick a new owner round-robin, each output having
// its own pointer. sel_r[o] doubles as the lock state: zero means idle,
// otherwise it is the one-hot owner.
module switch_allocator #(
    parameter int NP = 5,
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NP-1:0] req,
    input  logic [DW-1:0] dst0,
    input  logic [DW-1:0] dst1,
    input  logic [DW-1:0] dst2,
    input  logic [DW-1:0] dst3,
    input  logic [DW-1:0] dst4,
    input  logic [NP-1:0] tail,
    input  logic [NP-1:0] out_ready,
    output logic [NP-1:0] sel0,
    output logic [NP-1:0] sel1,
    output logic [NP-1:0] sel2,
    output logic [NP-1:0] sel3,
    output logic [NP-1:0] sel4,
    output logic [NP-1:0] gnt
);

    logic [DW-1:0] dst_s     [NP];
    logic [NP-1:0] sel_r     [NP];
    logic [DW-1:0] ptr_r     [NP];
    logic [NP-1:0] win_vec_s [NP];
    logic [DW-1:0] win_idx_s [NP];
    logic [NP-1:0] release_s;
    logic [NP-1:0] owner_s;
    logic [NP-1:0] gnt_s;

    // First candidate found scanning upward from ptr, wrapping modulo NP.
    function automatic logic [DW-1:0] rr_pick(input logic [NP-1:0] cand,
                                              input logic [DW-1:0] ptr);
        logic [DW-1:0] pick;
        logic          found;
        int            t;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NP; k++) begin
            t = int'(ptr) + k;
            if (t >= NP) begin
                t = t - NP;
            end
            if (!found && cand[t]) begin
                found = 1'b1;
                pick  = DW'(t);
            end
        end
        return pick;
    endfunction

    // Pointer value following a winner: one past it, modulo NP.
    function automatic logic [DW-1:0] rr_next(input logic [DW-1:0] w);
        return (int'(w) == NP - 1) ? DW'(0) : (w + DW'(1));
    endfunction

    assign dst_s[0] = dst0;
    assign dst_s[1] = dst1;
    assign dst_s[2] = dst2;
    assign dst_s[3] = dst3;
    assign dst_s[4] = dst4;

    assign sel0 = sel_r[0];
    assign sel1 = sel_r[1];
    assign sel2 = sel_r[2];
    assign sel3 = sel_r[3];
    assign sel4 = sel_r[4];
    assign gnt  = gnt_s;

    // Which inputs currently own an output, and which owners may move a flit.
    always_comb begin
        owner_s = '0;
        gnt_s   = '0;
        for (int o = 0; o < NP; o++) begin
            owner_s = owner_s | sel_r[o];
            for (int i = 0; i < NP; i++) begin
                gnt_s[i] = gnt_s[i] | (sel_r[o][i] & req[i] & out_ready[o]);
            end
        end
    end

    // An output is released when its owner moves the tail flit.
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            release_s[o] = |(sel_r[o] & gnt_s & tail);
        end
    end

    // Round-robin pick per idle output; an input already taken by a
    // lower-numbered output this cycle is withheld from the higher ones.
    always_comb begin : arb
        logic [NP-1:0] taken_v;
        logic [NP-1:0] cand_v;
        taken_v = '0;
        for (int o = 0; o < NP; o++) begin
            cand_v = '0;
            for (int i = 0; i < NP; i++) begin
                if (req[i] && (dst_s[i] == DW'(o)) && !owner_s[i] && !taken_v[i]) begin
                    cand_v[i] = 1'b1;
                end else begin
                    cand_v[i] = 1'b0;
                end
            end
            win_idx_s[o] = rr_pick(cand_v, ptr_r[o]);
            if ((sel_r[o] == '0) && (cand_v != '0)) begin
                win_vec_s[o] = NP'(1) << win_idx_s[o];
                taken_v      = taken_v | win_vec_s[o];
            end else begin
                win_vec_s[o] = '0;
            end
        end
    end

    // Lock/release state and pointers; a released output stays idle for one
    // cycle because arbitration only considers outputs that were idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < NP; o++) begin
                sel_r[o] <= '0;
                ptr_r[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (sel_r[o] != '0) begin
                    if (release_s[o]) begin
                        sel_r[o] <= '0;
                    end
                end else if (win_vec_s[o] != '0) begin
                    sel_r[o] <= win_vec_s[o];
                    ptr_r[o] <= rr_next(win_idx_s[o]);
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator with hand-computed expectations.
module tb_switch_allocator;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic [2:0] dst [5];
    logic [4:0] tail;
    logic [4:0] out_ready;
    logic [4:0] sel [5];
    logic [4:0] gnt;

    int tests_run;
    int tests_failed;

    switch_allocator #(.NP(5), .DW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .dst0      (dst[0]),
        .dst1      (dst[1]),
        .dst2      (dst[2]),
        .dst3      (dst[3]),
        .dst4      (dst[4]),
        .tail      (tail),
        .out_ready (out_ready),
        .sel0      (sel[0]),
        .sel1      (sel[1]),
        .sel2      (sel[2]),
        .sel3      (sel[3]),
        .sel4      (sel[4]),
        .gnt       (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req       = 5'b00000;
        tail      = 5'b00000;
        out_ready = 5'b11111;
        for (int i = 0; i < 5; i++) dst[i] = 3'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    function automatic logic [4:0] sel_or();
        return sel[0] | sel[1] | sel[2] | sel[3] | sel[4];
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clear_inputs();
        rst = 1'b0;
        #12;
        chk("reset_sel", 32'(sel_or()), 32'h0);
        chk("reset_gnt", 32'(gnt), 32'h0);
        rst = 1'b1;

        // Single-flit packet, input 1 -> output 2.
        req = 5'b00010; dst[1] = 3'd2; tail = 5'b00010;
        #1;
        chk("t1_gnt_pre", 32'(gnt), 32'h0);
        tick();
        chk("t1_sel2_lock", 32'(sel[2]), 32'h02);
        chk("t1_gnt", 32'(gnt), 32'h02);
        tick();
        req = 5'b00000; tail = 5'b00000;
        #1;
        chk("t1_sel2_rel", 32'(sel[2]), 32'h0);
        chk("t1_gnt_rel", 32'(gnt), 32'h0);
        // ptr_2 is now 2: inputs 0 and 3 contend, 3 is first in scan 2,3,...
        req = 5'b01001; dst[0] = 3'd2; dst[3] = 3'd2;
        tick();
        chk("t1_ptr_win3", 32'(sel[2]), 32'h08);
        chk("t1_ptr_gnt3", 32'(gnt), 32'h08);
        tail = 5'b01000;
        tick();
        req = 5'b00001; tail = 5'b00000;
        #1;
        chk("t1_bubble", 32'(sel[2]), 32'h0);
        tick();
        chk("t1_after_bubble", 32'(sel[2]), 32'h01);

        // Contention on output 4 among inputs 0,1,3.
        do_reset();
        req = 5'b01011; dst[0] = 3'd4; dst[1] = 3'd4; dst[3] = 3'd4;
        tick();
        chk("t2_first", 32'(sel[4]), 32'h01);
        chk("t2_gnt1", 32'(gnt), 32'h01);
        tick();
        chk("t2_gnt2", 32'(gnt), 32'h01);
        tick();
        tail = 5'b00001;
        #1;
        chk("t2_gnt3", 32'(gnt), 32'h01);
        tick();
        req = 5'b01010; tail = 5'b00000;
        #1;
        chk("t2_bubble", 32'(sel[4]), 32'h0);
        tick();
        chk("t2_second", 32'(sel[4]), 32'h02);
        tail = 5'b00010;
        tick();
        req = 5'b01000; tail = 5'b00000;
        #1;
        chk("t2_bubble2", 32'(sel[4]), 32'h0);
        tick();
        chk("t2_third", 32'(sel[4]), 32'h08);

        // Backpressure, dst change and req drop while locked.
        do_reset();
        req = 5'b00100; dst[2] = 3'd0; out_ready = 5'b11110;
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("t3_bp_sel0", 32'(sel[0]), 32'h04);
            chk("t3_bp_gnt", 32'(gnt), 32'h0);
            tick();
        end
        out_ready = 5'b11111;
        #1;
        chk("t3_resume", 32'(gnt), 32'h04);
        dst[2] = 3'd3;
        tick();
        chk("t3_dstchg_sel0", 32'(sel[0]), 32'h04);
        chk("t3_dstchg_sel3", 32'(sel[3]), 32'h0);
        chk("t3_dstchg_gnt", 32'(gnt), 32'h04);
        req = 5'b00000;
        #1;
        chk("t3_drop_gnt", 32'(gnt), 32'h0);
        tick();
        chk("t3_drop_hold", 32'(sel[0]), 32'h04);

        // Parallel locks on three outputs.
        do_reset();
        req = 5'b10011; dst[0] = 3'd3; dst[1] = 3'd2; dst[4] = 3'd0;
        tick();
        chk("t4_sel3", 32'(sel[3]), 32'h01);
        chk("t4_sel2", 32'(sel[2]), 32'h02);
        chk("t4_sel0", 32'(sel[0]), 32'h10);
        chk("t4_gnt", 32'(gnt), 32'h13);

        // Invalid destination is ignored.
        do_reset();
        req = 5'b01000; dst[3] = 3'd7;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t5_sel", 32'(sel_or()), 32'h0);
            chk("t5_gnt", 32'(gnt), 32'h0);
        end

        // Asynchronous reset mid-packet, then pointer restarts at 0.
        do_reset();
        req = 5'b00100; dst[2] = 3'd1;
        tick();
        chk("t6_lock", 32'(sel[1]), 32'h04);
        chk("t6_gnt", 32'(gnt), 32'h04);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_sel1", 32'(sel[1]), 32'h0);
        chk("t6_async_gnt", 32'(gnt), 32'h0);
        rst = 1'b1;
        req = 5'b10100; dst[4] = 3'd1;
        tick();
        chk("t6_ptr_reset", 32'(sel[1]), 32'h04);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
